nco_phase_accumulator_mc: RTL



---
 rtl/nco_pkg.sv | 18 +
 rtl/nco_phase_channel.sv | 73 +++++++
 rtl/nco_phase_accumulator_mc.sv | 77 +++++++
 3 files changed

// File: rtl/nco_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nco_pkg
// Brief   : Shared constants and helpers for the multi-channel NCO phase path.
// Revision: 1.0 - initial release
// ============================================================================
package nco_pkg;

    localparam logic CFG_SEL_FREQ   = 1'b0;
    localparam logic CFG_SEL_OFFSET = 1'b1;

    // Channel-select width; a single channel still needs a 1-bit select port.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nco_phase_channel.sv
`default_nettype none
// ============================================================================
// Module  : nco_phase_channel
// Brief   : One NCO channel: shadow/active config, phase accumulator, output stage.
// Revision: 1.0 - initial release
// ============================================================================
module nco_phase_channel #(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_freq_we,
    input  logic                 i_off_we,
    input  logic [ACC_WIDTH-1:0] i_cfg_data,
    input  logic                 i_cfg_update,
    input  logic                 i_ch_en,
    input  logic                 i_phase_clear,
    output logic [OUT_WIDTH-1:0] o_phase_out,
    output logic                 o_wrap
);

    logic [ACC_WIDTH-1:0] r_shadow_freq;
    logic [ACC_WIDTH-1:0] r_shadow_off;
    logic [ACC_WIDTH-1:0] r_act_freq;
    logic [ACC_WIDTH-1:0] r_act_off;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_carry;
    logic [OUT_WIDTH-1:0] r_phase;
    logic                 r_wrap;

    logic [ACC_WIDTH:0]   w_inc;
    logic [ACC_WIDTH-1:0] w_offset_sum;

    assign w_inc        = {1'b0, r_acc} + {1'b0, r_act_freq};
    // Offset is applied only on the output side so it never disturbs acc or wrap.
    assign w_offset_sum = r_acc + r_act_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_freq <= '0;
            r_shadow_off  <= '0;
            r_act_freq    <= '0;
            r_act_off     <= '0;
            r_acc         <= '0;
            r_carry       <= 1'b0;
            r_phase       <= '0;
            r_wrap        <= 1'b0;
        end else begin
            if (i_freq_we) r_shadow_freq <= i_cfg_data;
            if (i_off_we)  r_shadow_off  <= i_cfg_data;
            if (i_cfg_update) begin
                r_act_freq <= r_shadow_freq;
                r_act_off  <= r_shadow_off;
            end
            if (i_phase_clear) begin
                r_acc   <= '0;
                r_carry <= 1'b0;
            end else if (i_ch_en) begin
                {r_carry, r_acc} <= w_inc;
            end else begin
                r_carry <= 1'b0;
            end
            r_phase <= OUT_WIDTH'(w_offset_sum >> (ACC_WIDTH - OUT_WIDTH));
            r_wrap  <= r_carry;
        end
    end

    assign o_phase_out = r_phase;
    assign o_wrap      = r_wrap;

endmodule
`default_nettype wire

// File: rtl/nco_phase_accumulator_mc.sv
`default_nettype none
// ============================================================================
// Module  : nco_phase_accumulator_mc
// Brief   : NUM_CH-channel NCO phase accumulator with shared config decode.
// Revision: 1.0 - initial release
// ============================================================================
module nco_phase_accumulator_mc
    import nco_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 12,
    parameter int NUM_CH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [ch_width(NUM_CH)-1:0]   cfg_ch,
    input  logic                          cfg_sel,
    input  logic [ACC_WIDTH-1:0]          cfg_data,
    input  logic                          cfg_update,
    input  logic [NUM_CH-1:0]             ch_en,
    input  logic [NUM_CH-1:0]             phase_clear,
    output logic [NUM_CH*OUT_WIDTH-1:0]   phase_out,
    output logic [NUM_CH-1:0]             wrap,
    output logic                          out_valid
);

    localparam int CH_W = ch_width(NUM_CH);

    logic r_warm;
    logic r_out_valid;

    // Select values >= NUM_CH match no channel, so such writes are dropped.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [CH_W-1:0] c_idx = CH_W'(gi);
            logic w_hit;
            logic w_freq_we;
            logic w_off_we;

            assign w_hit     = cfg_we && (cfg_ch == c_idx);
            assign w_freq_we = w_hit && (cfg_sel == CFG_SEL_FREQ);
            assign w_off_we  = w_hit && (cfg_sel == CFG_SEL_OFFSET);

            nco_phase_channel #(
                .ACC_WIDTH (ACC_WIDTH),
                .OUT_WIDTH (OUT_WIDTH)
            ) u_ch (
                .clk           (clk),
                .rst           (rst),
                .i_freq_we     (w_freq_we),
                .i_off_we      (w_off_we),
                .i_cfg_data    (cfg_data),
                .i_cfg_update  (cfg_update),
                .i_ch_en       (ch_en[gi]),
                .i_phase_clear (phase_clear[gi]),
                .o_phase_out   (phase_out[gi*OUT_WIDTH +: OUT_WIDTH]),
                .o_wrap        (wrap[gi])
            );
        end
    endgenerate

    // Two-stage warm-up matches the accumulator-to-output pipeline depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_warm      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_warm      <= 1'b1;
            r_out_valid <= r_warm;
        end
    end

    assign out_valid = r_out_valid;

endmodule
`default_nettype wire
